// File: rtl/sign_mag_add_arbiter.sv
// sign_mag_add_arbiter: round-robin shared N-bit sign-magnitude adder for two clients (macro SIGN_MAG_NEG_ZERO_FIX_EN suppresses -0)
module sign_mag_add_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         vld,
  output logic         id,
  output logic [N-1:0] sum,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t       r_state;
  logic [N-1:0] r_op_a, r_op_b;
  logic         r_win, r_ptr;
  logic [N-2:0] w_mag_a, w_mag_b, w_max, w_min;
  logic [N-1:0] w_mag_sum;
  logic         w_same, w_sign, w_sign_out, w_ovf, w_pick1;
  assign w_mag_a   = r_op_a[N-2:0];
  assign w_mag_b   = r_op_b[N-2:0];
  assign w_max     = (w_mag_a > w_mag_b) ? w_mag_a : w_mag_b;
  assign w_min     = (w_mag_a > w_mag_b) ? w_mag_b : w_mag_a;
  assign w_sign    = (w_mag_a > w_mag_b) ? r_op_a[N-1] : r_op_b[N-1];
  assign w_same    = r_op_a[N-1] == r_op_b[N-1];
  assign w_mag_sum = w_same ? {1'b0, w_max} + {1'b0, w_min} : {1'b0, w_max} - {1'b0, w_min};
  assign w_ovf     = w_same & w_mag_sum[N-1];
`ifdef SIGN_MAG_NEG_ZERO_FIX_EN
  assign w_sign_out = w_sign & (|w_mag_sum[N-2:0]);
`else
  assign w_sign_out = w_sign;
`endif
  // client 1 wins when it is alone or when the pointer favours it
  assign w_pick1 = req1 & (~req0 | r_ptr);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_win   <= 1'b0;
      r_ptr   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      vld     <= 1'b0;
      id      <= 1'b0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          vld  <= 1'b0;
          if (req0 | req1) begin
            r_op_a  <= w_pick1 ? a1 : a0;
            r_op_b  <= w_pick1 ? b1 : b0;
            r_win   <= w_pick1;
            r_ptr   <= ~w_pick1;
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          sum     <= {w_sign_out, w_mag_sum[N-2:0]};
          ovf     <= w_ovf;
          id      <= r_win;
          vld     <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          vld     <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sign_mag_add_arbiter.sv
// tb_sign_mag_add_arbiter: directed self-checking bench for the shared sign-magnitude adder
module tb_sign_mag_add_arbiter;
  logic       clk = 1'b0, reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, busy, vld, id, ovf;
  logic [3:0] sum;
  int         n_checks = 0, n_err = 0;
`ifdef SIGN_MAG_NEG_ZERO_FIX_EN
  localparam logic [3:0] NEG_ZERO = 4'b0000;
`else
  localparam logic [3:0] NEG_ZERO = 4'b1000;
`endif
  sign_mag_add_arbiter #(.N(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .vld(vld),
    .id(id), .sum(sum), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic c, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es, input logic eo);
    if (c) begin a1 = a; b1 = b; req1 = 1'b1; end
    else   begin a0 = a; b0 = b; req0 = 1'b1; end
    @(posedge clk); #1;
    check("gnt_win", c ? gnt1 : gnt0, 1);
    check("gnt_lose", c ? gnt0 : gnt1, 0);
    check("busy_calc", busy, 1);
    check("vld_calc", vld, 0);
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b;
    @(posedge clk); #1;
    check("vld_resp", vld, 1);
    check("sum", sum, es);
    check("ovf", ovf, eo);
    check("id", id, c);
    check("gnt_clr", {gnt1, gnt0}, 0);
    check("busy_resp", busy, 1);
    @(posedge clk); #1;
    check("vld_drop", vld, 0);
    check("busy_drop", busy, 0);
    check("sum_hold", sum, es);
  endtask
  task automatic pair();
    a0 = 4'b0001; b0 = 4'b0001; a1 = 4'b0010; b1 = 4'b0010;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    check("pair_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("pair_vld0", vld, 1);
    check("pair_id0", id, 0);
    check("pair_sum0", sum, 4'b0010);
    @(posedge clk); #1;
    check("pair_idle", {gnt1, gnt0}, 0);
    @(posedge clk); #1;
    check("pair_gnt1", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    @(posedge clk); #1;
    check("pair_vld1", vld, 1);
    check("pair_id1", id, 1);
    check("pair_sum1", sum, 4'b0100);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out", {gnt0, gnt1, busy, vld, id, ovf}, 0);
    check("rst_sum", sum, 0);
    do_op(0, 4'b0011, 4'b0010, 4'b0101, 0);
    do_op(1, 4'b0011, 4'b1101, 4'b1010, 0);
    do_op(0, 4'b0110, 4'b0011, 4'b0001, 1);
    do_op(0, 4'b1110, 4'b1011, 4'b1001, 1);
    do_op(0, 4'b0011, 4'b1011, NEG_ZERO, 0);
    do_op(0, 4'b1000, 4'b1000, NEG_ZERO, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pair();
    pair();
    a0 = 4'b0001; b0 = 4'b0010; req0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("lone_gnt", gnt0, 1);
      @(posedge clk); #1;
      check("lone_sum", sum, 4'b0011);
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    a1 = 4'b0001; b1 = 4'b0010; req1 = 1'b1;
    @(posedge clk); #1;
    check("mid_gnt1", gnt1, 1);
    req1 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out", {gnt0, gnt1, busy, vld, id, ovf}, 0);
    check("mid_rst_sum", sum, 0);
    @(posedge clk); #1;
    check("mid_no_vld", {vld, busy}, 0);
    do_op(1, 4'b0010, 4'b1001, 4'b0001, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
